// File: rtl/vfu_reduce_acc.sv
// vfu_reduce_acc
//   Sums every lane of the packed VFU result word over a programmed number of
//   beats and returns one wide signed total per pass. The LayerNorm controller
//   uses it for the mean (sum of x) and, in multiply mode, the variance term
//   (sum of x*x).
//
//   Pipeline: stage 1 registers the sign-extended lane-adder-tree sum of an
//   accepted beat; stage 2 folds it into the accumulator. A three-state pass
//   FSM (IDLE -> ACC -> FLUSH) sequences the pass. FLUSH adds the still
//   in-flight stage-1 value and publishes the total.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, priority over all inputs
//   start      begin a pass (sampled only in IDLE)
//   len        beats in the pass, sampled with start (0 allowed)
//   in_valid   in_data carries a beat this cycle (honoured only in ACC)
//   in_data    packed lanes, lane i at bits [i*WIDTH +: WIDTH]
//   busy       high whenever the FSM is not in IDLE
//   out_valid  one-cycle pulse when out_sum holds a new total
//   out_sum    signed total of the last completed pass, held until the next

module vfu_reduce_acc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 busy,
    output logic                 out_valid,
    output logic [ACC_W-1:0]     out_sum
);

    // Lane-sum width: one extra bit per doubling of the lane count.
    localparam int unsigned LS_W  = WIDTH + $clog2(N);
    localparam int unsigned EXT_W = ACC_W - LS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [LEN_W-1:0]        remaining;
    logic [ACC_W-1:0]        acc;
    logic signed [LS_W-1:0]  lane_sum;
    logic                    s1_vld;

    logic signed [LS_W-1:0]  lane_sum_c;
    logic [ACC_W-1:0]        lane_sum_ext_c;
    logic                    beat_c;
    logic                    start_c;
    logic                    last_beat_c;

    // Qualified events: beats count only in ACC, start only in IDLE.
    assign beat_c      = (state == ACC) && in_valid;
    assign start_c     = (state == IDLE) && start;
    assign last_beat_c = beat_c && (remaining == LEN_W'(1));

    // Stage-1 value sign-extended to accumulator width.
    assign lane_sum_ext_c = {{EXT_W{lane_sum[LS_W-1]}}, lane_sum};

    // Lane adder tree: each lane is sign-extended before summing so the
    // LS_W-bit result cannot wrap.
    always_comb begin
        logic signed [WIDTH-1:0] lane;
        lane       = '0;
        lane_sum_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lane       = in_data[i*WIDTH +: WIDTH];
            lane_sum_c = lane_sum_c + LS_W'(lane);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_c) begin
                    state_nxt = (len != '0) ? ACC : FLUSH;
                end
            end
            ACC: begin
                if (last_beat_c) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; busy is registered from the next state so it tracks
    // "FSM not in IDLE" without a combinational output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Stage 1: capture the lane sum of each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_sum <= '0;
            s1_vld   <= 1'b0;
        end else begin
            s1_vld <= beat_c;
            if (beat_c) begin
                lane_sum <= lane_sum_c;
            end
        end
    end

    // Beat counter: loaded on start, decremented per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (start_c) begin
            remaining <= len;
        end else if (beat_c) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Stage 2: accumulator and result publication. The final beat's stage-1
    // value is still in flight during FLUSH, so it is added directly into
    // out_sum rather than through acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_c) begin
                        acc <= '0;
                    end
                end
                ACC: begin
                    if (s1_vld) begin
                        acc <= acc + lane_sum_ext_c;
                    end
                end
                FLUSH: begin
                    out_sum   <= acc + (s1_vld ? lane_sum_ext_c : '0);
                    out_valid <= 1'b1;
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vfu_reduce_acc.sv
// Self-checking bench for vfu_reduce_acc: a driver issues passes and pushes
// the expected total and arrival cycle into a queue; a negedge monitor pops
// and compares whenever out_valid is seen, and checks hold/reset behaviour.

module tb_vfu_reduce_acc;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 4;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned DW    = N * WIDTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             busy;
    logic             out_valid;
    logic [ACC_W-1:0] out_sum;

    vfu_reduce_acc #(
        .WIDTH(WIDTH),
        .N    (N),
        .LEN_W(LEN_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .out_valid(out_valid),
        .out_sum  (out_sum)
    );

    typedef struct {
        logic [ACC_W-1:0] sum;
        int               due;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [ACC_W-1:0] held   = '0;
    logic             rst_last = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_last) begin
            chk("rst_busy", longint'(busy), 0);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_sum", longint'(out_sum), 0);
            held = '0;
        end else if (out_valid) begin
            chk("busy_low_at_valid", longint'(busy), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: out_valid with out_sum %0h, none expected (cycle %0d)", out_sum, cyc);
            end else begin
                e = q.pop_front();
                chk("out_sum", longint'(out_sum), longint'(e.sum));
                chk("latency_cycle", longint'(cyc), longint'(e.due));
                held = e.sum;
            end
        end else begin
            chk("out_sum_hold", longint'(out_sum), longint'(held));
            if (q.size() > 0 && cyc > q[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: none at cycle %0d, expected sum %0h", q[0].due, q[0].sum);
                void'(q.pop_front());
            end
        end
        rst_last = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pass. pat_mode 0 = random lanes, 1 = every lane equals cval.
    task automatic run_pass(input int l, input int pat_mode, input logic [WIDTH-1:0] cval,
                            input int gap_pct, input bit b2b, input bit mid_start);
        logic [DW-1:0]    beats[$];
        logic [DW-1:0]    w;
        logic [WIDTH-1:0] lane;
        longint           tot;
        exp_t             e;
        int               last;

        // Reference: plain signed sum of every lane of every beat, mod 2^ACC_W.
        tot = 0;
        for (int i = 0; i < l; i++) begin
            w = (pat_mode == 0) ? {$urandom, $urandom} : {N{cval}};
            beats.push_back(w);
            for (int k = 0; k < int'(N); k++) begin
                lane = w[k*WIDTH +: WIDTH];
                tot += longint'($signed(lane));
            end
        end
        e.sum = tot[ACC_W-1:0];

        start    = 1'b1;
        len      = LEN_W'(l);
        in_valid = 1'($urandom);
        in_data  = {$urandom, $urandom};
        last     = cyc;
        step();
        start = 1'b0;
        chk("busy_rise", longint'(busy), 1);

        for (int i = 0; i < l; i++) begin
            if (mid_start && i == 1) begin
                start = 1'b1;
                len   = LEN_W'($urandom_range(1, 200));
            end
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                step();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            last     = cyc;
            step();
            start = 1'b0;
        end

        e.due = last + 2;
        q.push_back(e);

        // Extra beats after the last one must be ignored.
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        step();
        if (!b2b) begin
            repeat ($urandom_range(1, 3)) begin
                in_valid = 1'($urandom);
                in_data  = {$urandom, $urandom};
                step();
            end
            in_valid = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        run_pass(4,   1, 16'h0001, 0,  0, 0);
        run_pass(3,   1, 16'hFFFF, 50, 0, 0);
        run_pass(255, 1, 16'h7FFF, 0,  0, 0);
        run_pass(255, 1, 16'h8000, 0,  0, 0);
        run_pass(0,   1, 16'h0000, 0,  0, 0);
        run_pass(6,   0, 16'h0000, 30, 0, 1);

        // Reset after 2 of 4 beats, with a beat presented alongside rst.
        start    = 1'b1;
        len      = LEN_W'(4);
        in_valid = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = {N{16'h0005}};
            step();
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (4) step();

        run_pass(2, 1, 16'h0003, 0, 1, 0);
        run_pass(5, 0, 16'h0000, 0, 0, 0);

        for (int p = 0; p < 25; p++) begin
            int l;
            l = $urandom_range(0, 20);
            run_pass(l, int'($urandom_range(0, 1)), WIDTH'($urandom), int'($urandom_range(0, 60)),
                     1'($urandom), (l >= 2) ? 1'($urandom) : 1'b0);
        end
        run_pass(1, 0, 16'h0000, 0, 1, 0);
        run_pass(0, 0, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still outstanding", q.size());
        end
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vfu_reduce_acc.md
# vfu_reduce_acc

Vector reduction accumulator that sits directly downstream of the VFU result register. It consumes the packed N-lane result word and sums all lanes over a programmed number of beats. It returns one wide signed total per pass, which the LayerNorm controller uses to form the mean (Σx) and, when the VFU runs in multiply mode on x·x, the variance term (Σx²). Internally it has a two-stage pipeline (lane adder tree, then accumulator) with a small pass-control FSM.

## Interface
- WIDTH, 16, bit width of one signed two's-complement lane
- N, 4, lanes per beat (power of 2, ≥1)
- LEN_W, 8, width of the beat-count field
- ACC_W, 32, accumulator/result width; must satisfy ACC_W ≥ WIDTH + log2(N) + LEN_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- len  in  LEN_W  beats in the pass, sampled with start (0 allowed)
- in_valid  in  1  in_data carries a beat this cycle
- in_data  in  N*WIDTH  packed lanes, lane i at bits [i*WIDTH +: WIDTH]
- busy  out  1  high whenever the FSM is not in IDLE
- out_valid  out  1  one-cycle pulse; out_sum holds a new total
- out_sum  out  ACC_W  signed total of the last completed pass; held until the next completion

## Operation
- States:
  - IDLE: start=1 → clear acc, load remaining ← len, clear stage-1 valid; next state ACC if len≠0, else FLUSH.
  - ACC: each cycle with in_valid=1 is an accepted beat.
    - Stage 1 registers lane_sum = sign-extended sum of all N lanes (width WIDTH+log2(N)), plus s1_vld.
    - remaining decrements on each accepted beat.
    - The beat that brings remaining to 0 also moves the FSM to FLUSH.
    - Cycles with in_valid=0 insert bubbles; no limit on gap length.
  - FLUSH: one cycle. out_sum ← acc + (s1_vld ? sext(lane_sum) : 0), out_valid ← 1 for exactly one cycle; next state IDLE.
- Accumulator stage:
  - In ACC, s1_vld=1 → acc ← acc + sext(lane_sum).
  - acc is ACC_W bits. Arithmetic is modulo 2^ACC_W; with legal parameters there is no overflow.
- Ignored inputs:
  - in_valid outside ACC, including the start cycle.
  - start outside IDLE.
  - len outside the start cycle.
- Reset values: busy=0, out_valid=0, out_sum=0. Internal: state=IDLE, acc=0, remaining=0, s1_vld=0, lane_sum=0.
- Reset mid-pass: the pass is abandoned, no out_valid is produced, and any in-flight beat is discarded.
- rst has priority over every other input in the same cycle.

## Timing
- Latency: last beat accepted in cycle T → out_valid=1 in cycle T+2 with the final out_sum.
- len=0: start in cycle T → out_valid=1 with out_sum=0 in cycle T+2.
- busy rises the cycle after start and falls in the cycle out_valid is high (FSM already IDLE).
- Back-to-back passes: start may be asserted in the cycle out_valid is high; it is accepted.
- Minimum pass time is len+2 cycles from start to out_valid.
- Throughput is one beat per cycle with no stall output; upstream must not present more beats than len. Extra beats after the last one are ignored because the FSM has left ACC.

## Test plan
- len=4, all lanes 0x0001 with in_valid continuous → out_valid exactly 2 cycles after the 4th beat, out_sum=16, single-cycle pulse, busy low in that cycle.
- len=3, all lanes 0xFFFF (−1), in_valid toggling 1,0,0,1,0,1 → out_sum=0xFFFFFFF4 (−12); bubbles do not count as beats.
- len=255, all lanes 0x7FFF → out_sum=0x01FDFC04 (33,422,340); repeat with 0x8000 → out_sum=−33,423,360 (0xFE020000).
- len=0: start → out_valid 2 cycles later with out_sum=0. in_valid asserted during that window has no effect.
- start pulsed during ACC with a different len, and in_valid asserted in IDLE → both ignored; result matches the original pass only.
- rst asserted after 2 of 4 beats → busy=0, out_valid=0, out_sum=0 next cycle and no pulse afterwards. A new pass with len=2 and lanes 0x0003 gives out_sum=24. A subsequent back-to-back start during out_valid gives a correct second total.
